// File: rtl/sel_decoder_pipe.sv
// Registered N-to-M one-hot select decoder with valid/ready handshakes and an autonomous SCAN walk.
// Optional saturating error counter (err_cnt) is built when SEL_DEC_ERR_CNT_EN is defined.
module sel_decoder_pipe #(
  parameter int unsigned IN_W    = 4,
  parameter int unsigned NUM_OUT = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               enable,
  input  logic [IN_W-1:0]    in,
  input  logic               scan_start,
  input  logic               scan_abort,
  output logic               scan_busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] sel,
  output logic               err
`ifdef SEL_DEC_ERR_CNT_EN
  ,
  output logic [7:0]         err_cnt
`endif
);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  localparam logic [IN_W-1:0] LastIdx = IN_W'(NUM_OUT - 1);

  state_e             state_q, state_d;
  logic [IN_W-1:0]    scan_idx_q, scan_idx_d;
  logic               abort_q, abort_d;
  logic               out_valid_q, out_valid_d;
  logic [NUM_OUT-1:0] sel_q, sel_d;
  logic               err_q, err_d;
  logic               slot_free;
  logic               load;
  logic               dir_err;
  logic [NUM_OUT-1:0] one_lsb;

  assign one_lsb   = NUM_OUT'(1);
  assign slot_free = !out_valid_q || out_ready;
  assign dir_err   = enable && (32'(in) >= NUM_OUT);

  always_comb begin
    state_d     = state_q;
    scan_idx_d  = scan_idx_q;
    abort_d     = abort_q;
    out_valid_d = out_valid_q;
    sel_d       = sel_q;
    err_d       = err_q;
    load        = 1'b0;
    in_ready    = 1'b0;
    if (slot_free) begin
      out_valid_d = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        in_ready = slot_free && !scan_start;
        if (slot_free && scan_start) begin
          load       = 1'b1;
          sel_d      = one_lsb;
          err_d      = 1'b0;
          scan_idx_d = IN_W'(1);
          abort_d    = 1'b0;
          state_d    = StScan;
        end else if (in_valid && in_ready) begin
          load  = 1'b1;
          err_d = dir_err;
          sel_d = (enable && !dir_err) ? (one_lsb << in) : '0;
        end
      end
      StScan: begin
        abort_d = abort_q || scan_abort;
        if (slot_free) begin
          // scan_idx is 0 inside SCAN only once the last line has been loaded
          if (abort_d || (scan_idx_q == '0)) begin
            state_d    = StIdle;
            scan_idx_d = '0;
            abort_d    = 1'b0;
          end else begin
            load       = 1'b1;
            sel_d      = one_lsb << scan_idx_q;
            err_d      = 1'b0;
            scan_idx_d = (scan_idx_q == LastIdx) ? '0 : scan_idx_q + IN_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      scan_idx_q  <= '0;
      abort_q     <= 1'b0;
      out_valid_q <= 1'b0;
      sel_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_idx_q  <= scan_idx_d;
      abort_q     <= abort_d;
      out_valid_q <= out_valid_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
    end
  end

  assign scan_busy = (state_q == StScan);
  assign out_valid = out_valid_q;
  assign sel       = sel_q;
  assign err       = err_q;

`ifdef SEL_DEC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (load && err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sel_decoder_pipe.sv
// Scoreboard bench for sel_decoder_pipe: a transaction-level model predicts every output,
// a negedge monitor compares; directed cases plus randomized traffic.
module tb_sel_decoder_pipe;
  localparam int unsigned IN_W    = 4;
  localparam int unsigned NUM_OUT = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic enable = 1'b0;
  logic scan_start = 1'b0;
  logic scan_abort = 1'b0;
  logic out_ready = 1'b0;
  logic [IN_W-1:0] in_idx = '0;
  logic in_ready, scan_busy, out_valid, err;
  logic [NUM_OUT-1:0] sel;
`ifdef SEL_DEC_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  typedef struct packed {
    logic [NUM_OUT-1:0] sel;
    logic               err;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int m_err_loads = 0;
  bit m_active = 1'b0;
  bit m_abort = 1'b0;
  int unsigned m_next = 0;

  always #5 clk = ~clk;

  sel_decoder_pipe #(
    .IN_W    (IN_W),
    .NUM_OUT (NUM_OUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .enable     (enable),
    .in         (in_idx),
    .scan_start (scan_start),
    .scan_abort (scan_abort),
    .scan_busy  (scan_busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sel        (sel),
    .err        (err)
`ifdef SEL_DEC_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t direct_exp(input logic en, input logic [IN_W-1:0] idx);
    exp_t e;
    e.err = en && (32'(idx) >= NUM_OUT);
    e.sel = '0;
    if (en && !e.err) e.sel[idx] = 1'b1;
    return e;
  endfunction

  function automatic exp_t scan_exp(input int unsigned k);
    exp_t e;
    e.err = 1'b0;
    e.sel = '0;
    e.sel[k] = 1'b1;
    return e;
  endfunction

  // Reference model and monitor: at each negedge the handshakes about to happen are known.
  always @(negedge clk) begin : model
    exp_t e;
    bit slot_free;
    if (!reset_n) begin
      exp_q.delete();
      m_active = 1'b0;
      m_abort = 1'b0;
      m_next = 0;
      m_err_loads = 0;
    end else begin
      slot_free = (exp_q.size() == 0) || out_ready;
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("scan_busy", 32'(scan_busy), 32'(m_active));
      check("in_ready", 32'(in_ready), 32'(!m_active && slot_free && !scan_start));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_output: actual sel %0h required no output", sel);
        end else begin
          e = exp_q.pop_front();
          check("sel", 32'(sel), 32'(e.sel));
          check("err", 32'(err), 32'(e.err));
        end
      end
      if (m_active) begin
        m_abort = m_abort || scan_abort;
        if (slot_free) begin
          if (m_abort || (m_next == NUM_OUT)) begin
            m_active = 1'b0;
            m_abort = 1'b0;
          end else begin
            exp_q.push_back(scan_exp(m_next));
            m_next++;
          end
        end
      end else if (scan_start && slot_free) begin
        m_active = 1'b1;
        m_abort = 1'b0;
        exp_q.push_back(scan_exp(0));
        m_next = 1;
      end else if (in_valid && slot_free) begin
        e = direct_exp(enable, in_idx);
        exp_q.push_back(e);
        if (e.err) m_err_loads++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic direct_req(input logic en, input logic [IN_W-1:0] idx, input string name);
    step();
    out_ready = 1'b1;
    in_valid = 1'b1;
    enable = en;
    in_idx = idx;
    step();
    in_valid = 1'b0;
    check(name, 32'(out_valid), 32'd1);
  endtask

  initial begin
    int waited;
    repeat (3) step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_scan_busy", 32'(scan_busy), 32'd0);
    reset_n = 1'b1;
    step();

    direct_req(1'b1, 4'd5, "direct5_latency");
    direct_req(1'b1, 4'd12, "range12_latency");
    direct_req(1'b0, 4'd3, "disable3_latency");
    direct_req(1'b1, 4'd9, "top_index_latency");
    direct_req(1'b1, 4'd10, "first_bad_index_latency");
    direct_req(1'b1, 4'd0, "index0_latency");
    repeat (2) step();

    // Full scan with a free consumer
    out_ready = 1'b1;
    scan_start = 1'b1;
    in_valid = 1'b1;
    enable = 1'b1;
    in_idx = 4'd2;
    step();
    scan_start = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < int'(NUM_OUT); k++) begin
      check("scan_valid", 32'(out_valid), 32'd1);
      check("scan_sel", 32'(sel), 32'd1 << k);
      step();
    end
    check("scan_end_busy", 32'(scan_busy), 32'd0);
    check("scan_end_in_ready", 32'(in_ready), 32'd1);
    repeat (2) step();

    // Backpressure on the third output, then abort
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    step();
    step();
    out_ready = 1'b0;
    check("abort_third_sel", 32'(sel), 32'h4);
    step();
    scan_start = 1'b1;
    scan_abort = 1'b1;
    step();
    scan_start = 1'b0;
    scan_abort = 1'b0;
    check("abort_hold_sel", 32'(sel), 32'h4);
    check("abort_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    check("abort_idle_busy", 32'(scan_busy), 32'd0);
    check("abort_no_next", 32'(out_valid), 32'd0);
    repeat (2) step();

    // Randomized traffic
    repeat (800) begin
      in_valid = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 3) != 0);
      in_idx = IN_W'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      scan_start = ($urandom_range(0, 24) == 0);
      scan_abort = ($urandom_range(0, 39) == 0);
      step();
    end

    // Reset in the middle of a scan
    in_valid = 1'b0;
    scan_abort = 1'b0;
    scan_start = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("midscan_rst_valid", 32'(out_valid), 32'd0);
    check("midscan_rst_sel", 32'(sel), 32'd0);
    check("midscan_rst_err", 32'(err), 32'd0);
    check("midscan_rst_busy", 32'(scan_busy), 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // Short random burst after reset, then drain
    repeat (200) begin
      in_valid = 1'($urandom_range(0, 1));
      enable = 1'b1;
      in_idx = IN_W'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      scan_start = ($urandom_range(0, 29) == 0);
      step();
    end
    in_valid = 1'b0;
    scan_start = 1'b0;
    out_ready = 1'b1;
    waited = 0;
    while (((exp_q.size() != 0) || m_active) && (waited < 100)) begin
      step();
      waited++;
    end
    n_cmp++;
    if (waited >= 100) begin
      n_bad++;
      $display("FAIL drain_timeout: actual %0d pending required 0", exp_q.size());
    end
    step();
`ifdef SEL_DEC_ERR_CNT_EN
    check("err_cnt", 32'(err_cnt), (m_err_loads > 255) ? 32'd255 : 32'(m_err_loads));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
